// File: rtl/nmr_seq_pkg.sv
// Shared types and constants for the CPMG pulse-train sequencer.
package nmr_seq_pkg;

   localparam int DLY_W_DEF = 32;
   localparam int CNT_W_DEF = 16;

   // XOR mask that flips a phase code by 180 degrees
   localparam logic [1:0] PH_ALT_MASK = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L90,
      ST_W90,
      ST_L180,
      ST_W180,
      ST_FIN
   } state_t;

   // Phase of a 180 pulse: odd echoes are flipped when alternation is enabled
   function automatic logic [1:0] p180_phase(input logic [1:0] ph,
                                             input logic       alt_en,
                                             input logic       odd);
      return (alt_en && odd) ? (ph ^ PH_ALT_MASK) : ph;
   endfunction

endpackage

// File: rtl/nmr_rise_det.sv
// Registered rising-edge detector for the bit streamer DONE line.
module nmr_rise_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,
   output logic o_rise
);

   logic r_din_d;
   logic r_rise;

   // Remember last sample and flag a 0->1 transition one cycle later
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_din_d <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_din_d <= i_din;
         r_rise  <= i_din & ~r_din_d;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/nmr_cpmg_sequencer.sv
// CPMG train sequencer: one 90 pulse followed by N 180 pulses, each
// executed by handing delays to the bit streamer and waiting for its DONE.
module nmr_cpmg_sequencer
   import nmr_seq_pkg::*;
#(
   parameter int DLY_W = DLY_W_DEF,
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [CNT_W-1:0] i_echo_n,
   input  logic [DLY_W-1:0] i_p90_idly,
   input  logic [DLY_W-1:0] i_p90_pls,
   input  logic [DLY_W-1:0] i_p90_edly,
   input  logic [DLY_W-1:0] i_p180_idly,
   input  logic [DLY_W-1:0] i_p180_pls,
   input  logic [DLY_W-1:0] i_p180_edly,
   input  logic [1:0]       i_ph90,
   input  logic [1:0]       i_ph180,
   input  logic             i_alt_en,
   output logic             o_bs_start,
   output logic [DLY_W-1:0] o_bs_idly,
   output logic [DLY_W-1:0] o_bs_pls,
   output logic [DLY_W-1:0] o_bs_edly,
   input  logic             i_bs_done,
   output logic [1:0]       o_phase,
   output logic [CNT_W-1:0] o_echo_idx,
   output logic             o_echo_tick,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;

   // Configuration captured at train start; inputs are ignored afterwards
   logic [CNT_W-1:0] r_echo_n;
   logic [DLY_W-1:0] r_p90_idly;
   logic [DLY_W-1:0] r_p90_pls;
   logic [DLY_W-1:0] r_p90_edly;
   logic [DLY_W-1:0] r_p180_idly;
   logic [DLY_W-1:0] r_p180_pls;
   logic [DLY_W-1:0] r_p180_edly;
   logic [1:0]       r_ph90;
   logic [1:0]       r_ph180;
   logic             r_alt_en;

   logic             r_bs_start;
   logic [DLY_W-1:0] r_bs_idly;
   logic [DLY_W-1:0] r_bs_pls;
   logic [DLY_W-1:0] r_bs_edly;
   logic [1:0]       r_phase;
   logic [CNT_W-1:0] r_echo_idx;
   logic             r_echo_tick;
   logic             r_busy;
   logic             r_done;

   logic             w_done_rise;
   logic [CNT_W-1:0] w_last_idx;

   // Last echo index in CNT_W bits so ECHO_N = max never lets the index wrap
   assign w_last_idx = r_echo_n - CNT_ONE;

   nmr_rise_det u_done_det (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_din  (i_bs_done),
      .o_rise (w_done_rise)
   );

   // Train FSM with registered outputs; abort outranks the DONE edge, which outranks start
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         r_echo_n    <= '0;
         r_p90_idly  <= '0;
         r_p90_pls   <= '0;
         r_p90_edly  <= '0;
         r_p180_idly <= '0;
         r_p180_pls  <= '0;
         r_p180_edly <= '0;
         r_ph90      <= '0;
         r_ph180     <= '0;
         r_alt_en    <= 1'b0;
         r_bs_start  <= 1'b0;
         r_bs_idly   <= '0;
         r_bs_pls    <= '0;
         r_bs_edly   <= '0;
         r_phase     <= '0;
         r_echo_idx  <= '0;
         r_echo_tick <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_bs_start  <= 1'b0;
         r_echo_tick <= 1'b0;
         r_done      <= 1'b0;
         if ((r_state != ST_IDLE) && i_abort) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_echo_idx <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_start && !i_abort) begin
                     r_echo_n    <= i_echo_n;
                     r_p90_idly  <= i_p90_idly;
                     r_p90_pls   <= i_p90_pls;
                     r_p90_edly  <= i_p90_edly;
                     r_p180_idly <= i_p180_idly;
                     r_p180_pls  <= i_p180_pls;
                     r_p180_edly <= i_p180_edly;
                     r_ph90      <= i_ph90;
                     r_ph180     <= i_ph180;
                     r_alt_en    <= i_alt_en;
                     r_echo_idx  <= '0;
                     r_busy      <= 1'b1;
                     r_state     <= ST_L90;
                  end
               end
               ST_L90: begin
                  r_bs_idly  <= r_p90_idly;
                  r_bs_pls   <= r_p90_pls;
                  r_bs_edly  <= r_p90_edly;
                  r_phase    <= r_ph90;
                  r_bs_start <= 1'b1;
                  r_state    <= ST_W90;
               end
               ST_W90: begin
                  if (w_done_rise) begin
                     r_state <= (r_echo_n != '0) ? ST_L180 : ST_FIN;
                  end
               end
               ST_L180: begin
                  r_bs_idly  <= r_p180_idly;
                  r_bs_pls   <= r_p180_pls;
                  r_bs_edly  <= r_p180_edly;
                  r_phase    <= p180_phase(r_ph180, r_alt_en, r_echo_idx[0]);
                  r_bs_start <= 1'b1;
                  r_state    <= ST_W180;
               end
               ST_W180: begin
                  if (w_done_rise) begin
                     r_echo_tick <= 1'b1;
                     if (r_echo_idx == w_last_idx) begin
                        r_state <= ST_FIN;
                     end else begin
                        r_echo_idx <= r_echo_idx + CNT_ONE;
                        r_state    <= ST_L180;
                     end
                  end
               end
               ST_FIN: begin
                  r_done     <= 1'b1;
                  r_echo_idx <= '0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_bs_start  = r_bs_start;
   assign o_bs_idly   = r_bs_idly;
   assign o_bs_pls    = r_bs_pls;
   assign o_bs_edly   = r_bs_edly;
   assign o_phase     = r_phase;
   assign o_echo_idx  = r_echo_idx;
   assign o_echo_tick = r_echo_tick;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule
